// File: rtl/dac8531_pkg.sv
// -----------------------------------------------------------------------------
// dac8531_pkg
// Shared definitions for the DAC8531 write-frame receiver: default frame
// length, bit positions of the power-down and data fields inside a frame,
// and the receiver state encoding.
// -----------------------------------------------------------------------------
package dac8531_pkg;

    localparam int FRAME_BITS_DEF = 24;

    // Frame layout, MSB first: 6 don't-care, PD[1:0], DATA[15:0]
    localparam int PD_MSB   = 17;
    localparam int PD_LSB   = 16;
    localparam int DATA_MSB = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/dac8531_spi_rx_if.sv
// -----------------------------------------------------------------------------
// dac8531_spi_rx_if
// The three DAC8531 serial pins as seen on the board.
//   DA_CS   : frame sync, active low (DAC SYNC)
//   DA_SCLK : serial clock, data sampled on its falling edge
//   DA_SDO  : serial data from the driver (DAC DIN)
// master : the DAC driver side, drives all three pins
// slave  : a passive listener (the receiver), only observes them
// -----------------------------------------------------------------------------
interface dac8531_spi_rx_if;

    logic DA_CS;
    logic DA_SCLK;
    logic DA_SDO;

    modport master (output DA_CS, output DA_SCLK, output DA_SDO);
    modport slave  (input  DA_CS, input  DA_SCLK, input  DA_SDO);

endinterface

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Brings one asynchronous SPI pin into the CLOCK_10M domain through a
// STAGES-deep flop chain, then keeps one extra registered copy so edges can
// be detected. All three SPI pins use identical instances, so they remain
// aligned to each other after synchronization.
// Ports:
//   CLOCK_10M, RESET_N : system clock, async active-low reset
//   din                : raw pin
//   level              : synchronized level
//   rise / fall        : single-cycle edge strobes of the synchronized level
// -----------------------------------------------------------------------------
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLOCK_10M,
    input  logic RESET_N,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac8531_spi_rx.sv
// -----------------------------------------------------------------------------
// dac8531_spi_rx
// Passive listener on the DAC8531 serial pins. Recovers the 16-bit code and
// power-down bits of each complete write frame, counts accepted frames and
// flags frames that end early (abort) or run long (overrun).
// Ports:
//   CLOCK_10M, RESET_N : system clock, async active-low reset
//   spi                : DA_CS / DA_SCLK / DA_SDO pins (slave view)
//   RX_DATA, RX_PD     : last accepted code and power-down bits
//   RX_VALID           : 1-cycle pulse when RX_DATA/RX_PD update
//   RX_ABORT           : 1-cycle pulse, CS rose before a full frame
//   RX_OVERRUN         : 1-cycle pulse, CS rose after extra SCLK falls
//   RX_BUSY            : synchronized CS is low
//   FRAME_CNT          : accepted frame count, wraps
// -----------------------------------------------------------------------------
module dac8531_spi_rx
    import dac8531_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLOCK_10M,
    input  logic                    RESET_N,
    dac8531_spi_rx_if.slave         spi,
    output logic [DATA_MSB:0]       RX_DATA,
    output logic [PD_MSB-PD_LSB:0]  RX_PD,
    output logic                    RX_VALID,
    output logic                    RX_ABORT,
    output logic                    RX_OVERRUN,
    output logic                    RX_BUSY,
    output logic [15:0]             FRAME_CNT
);

    localparam int                CNT_W     = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    // ---- stage: pin synchronization and edge detection ----
    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_fall, sdo_lvl;
    logic unused_sclk_lvl, unused_sclk_rise, unused_sdo_rise, unused_sdo_fall;

    // CS resets to its idle (high) level so RX_BUSY is low out of reset
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .CLOCK_10M (CLOCK_10M), .RESET_N (RESET_N), .din (spi.DA_CS),
        .level (cs_lvl), .rise (cs_rise), .fall (cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .CLOCK_10M (CLOCK_10M), .RESET_N (RESET_N), .din (spi.DA_SCLK),
        .level (unused_sclk_lvl), .rise (unused_sclk_rise), .fall (sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
        .CLOCK_10M (CLOCK_10M), .RESET_N (RESET_N), .din (spi.DA_SDO),
        .level (sdo_lvl), .rise (unused_sdo_rise), .fall (unused_sdo_fall)
    );

    // Edges are ignored until the synchronizers have flushed their reset
    // value; otherwise a CS held low across reset release would look like a
    // fresh frame start and later report a spurious abort.
    logic [WARM_W-1:0] warm_q;
    logic              armed;

    assign armed = (warm_q == WARM_DONE);

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N)    warm_q <= '0;
        else if (!armed) warm_q <= warm_q + 1'b1;
    end

    // ---- stage: frame FSM ----
    rx_state_e               state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d, shifted;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d, bit_inc;
    logic [DATA_MSB:0]       data_q, data_d;
    logic [PD_MSB-PD_LSB:0]  pd_q, pd_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    abort_q, abort_d;
    logic                    overrun_q, overrun_d;
    logic                    unused_shift_msb;

    // The oldest don't-care bit falls off the end and is never inspected
    assign unused_shift_msb = shift_q[FRAME_BITS-1];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        pd_d        = pd_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;
        abort_d     = 1'b0;
        overrun_d   = 1'b0;
        shifted     = {shift_q[FRAME_BITS-2:0], sdo_lvl};
        bit_inc     = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;

        if (armed) begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end
                end

                SHIFT: begin
                    if (cs_fall) begin
                        // Missed CS rise: the unfinished frame is abandoned
                        abort_d   = 1'b1;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        // SCLK fall is handled before a coincident CS rise
                        if (sclk_fall) begin
                            shift_d   = shifted;
                            bit_cnt_d = bit_inc;
                            if (bit_inc == CNT_LAST) begin
                                data_d      = shifted[DATA_MSB:0];
                                pd_d        = shifted[PD_MSB:PD_LSB];
                                valid_d     = 1'b1;
                                frame_cnt_d = frame_cnt_q + 1'b1;
                                state_d     = HOLD;
                            end
                        end
                        // A rise in the completing cycle is a clean HOLD exit
                        if (cs_rise) begin
                            abort_d = ~valid_d;
                            state_d = IDLE;
                        end
                    end
                end

                HOLD: begin
                    if (cs_fall) begin
                        ovf_d     = 1'b0;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end else begin
                        if (sclk_fall) begin
                            ovf_d     = 1'b1;
                            bit_cnt_d = bit_inc;
                        end
                        if (cs_rise) begin
                            overrun_d = ovf_d;
                            ovf_d     = 1'b0;
                            state_d   = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            pd_q        <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            pd_q        <= pd_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
        end
    end

    // ---- stage: outputs ----
    assign RX_DATA    = data_q;
    assign RX_PD      = pd_q;
    assign RX_VALID   = valid_q;
    assign RX_ABORT   = abort_q;
    assign RX_OVERRUN = overrun_q;
    assign RX_BUSY    = ~cs_lvl;
    assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_dac8531_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_dac8531_spi_rx
// Directed bench for dac8531_spi_rx: drives DAC8531 frames at SCLK = 1 MHz
// (10 system clocks per bit) and compares outputs and pulse counts against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_dac8531_spi_rx;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rx_data;
    logic [1:0]  rx_pd;
    logic        rx_valid, rx_abort, rx_overrun, rx_busy;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_abort  = 0;
    int n_over   = 0;
    int valid_cyc = -1;
    int fall_cyc  = 0;
    int b_valid, b_abort, b_over;

    always #50 clk = ~clk;

    dac8531_spi_rx_if spi_if ();

    dac8531_spi_rx #(.FRAME_BITS(24), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLOCK_10M  (clk),
        .RESET_N    (rst_n),
        .spi        (spi_if),
        .RX_DATA    (rx_data),
        .RX_PD      (rx_pd),
        .RX_VALID   (rx_valid),
        .RX_ABORT   (rx_abort),
        .RX_OVERRUN (rx_overrun),
        .RX_BUSY    (rx_busy),
        .FRAME_CNT  (frame_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (rx_abort)   n_abort <= n_abort + 1;
        if (rx_overrun) n_over  <= n_over + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        b_valid = n_valid;
        b_abort = n_abort;
        b_over  = n_over;
    endtask

    // Sends the n low bits of word MSB first; SCLK idles high and falls mid-bit.
    // With rise_with_last, CS rises at the pin on the same cycle as the last fall.
    task automatic send_frame(input logic [31:0] word, input int n, input bit rise_with_last);
        @(negedge clk);
        spi_if.DA_CS   = 1'b0;
        spi_if.DA_SCLK = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            spi_if.DA_SDO = word[i];
            repeat (5) @(negedge clk);
            spi_if.DA_SCLK = 1'b0;
            if (i == n - 24) fall_cyc = cyc;
            if (i == 0 && rise_with_last) spi_if.DA_CS = 1'b1;
            repeat (5) @(negedge clk);
            spi_if.DA_SCLK = 1'b1;
        end
        if (!rise_with_last) begin
            repeat (2) @(negedge clk);
            spi_if.DA_CS = 1'b1;
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        spi_if.DA_CS   = 1'b1;
        spi_if.DA_SCLK = 1'b1;
        spi_if.DA_SDO  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy_in_reset", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("rst_data",  {16'd0, rx_data}, 32'd0);
        check_val("rst_pd",    {30'd0, rx_pd}, 32'd0);
        check_val("rst_cnt",   {16'd0, frame_cnt}, 32'd0);
        check_val("rst_busy",  {31'd0, rx_busy}, 32'd0);
        check_val("rst_pulses", {29'd0, rx_valid, rx_abort, rx_overrun}, 32'd0);

        // Plain frame 0x007A30
        snap();
        send_frame(32'h007A30, 24, 1'b0);
        check_val("f1_data",    {16'd0, rx_data}, 32'h7A30);
        check_val("f1_pd",      {30'd0, rx_pd}, 32'd0);
        check_val("f1_nvalid",  n_valid - b_valid, 32'd1);
        check_val("f1_latency", valid_cyc - fall_cyc, SYNC_STAGES + 1);
        check_val("f1_cnt",     {16'd0, frame_cnt}, 32'd1);
        check_val("f1_nabort",  n_abort - b_abort, 32'd0);
        check_val("f1_busy_after", {31'd0, rx_busy}, 32'd0);

        // All ones, both PD bits set
        snap();
        send_frame(32'h03FFFF, 24, 1'b0);
        check_val("f2_data",   {16'd0, rx_data}, 32'hFFFF);
        check_val("f2_pd",     {30'd0, rx_pd}, 32'd3);
        check_val("f2_nvalid", n_valid - b_valid, 32'd1);
        check_val("f2_cnt",    {16'd0, frame_cnt}, 32'd2);

        // Short 12-bit frame aborts and leaves outputs alone
        snap();
        send_frame(32'h000ABC, 12, 1'b0);
        check_val("ab_nabort", n_abort - b_abort, 32'd1);
        check_val("ab_nvalid", n_valid - b_valid, 32'd0);
        check_val("ab_data",   {16'd0, rx_data}, 32'hFFFF);
        check_val("ab_pd",     {30'd0, rx_pd}, 32'd3);
        check_val("ab_cnt",    {16'd0, frame_cnt}, 32'd2);

        // 30-bit frame: accepted after 24 bits, overrun at CS rise
        snap();
        send_frame((32'h001234 << 6) | 32'h2A, 30, 1'b0);
        check_val("ov_nvalid",  n_valid - b_valid, 32'd1);
        check_val("ov_latency", valid_cyc - fall_cyc, SYNC_STAGES + 1);
        check_val("ov_data",    {16'd0, rx_data}, 32'h1234);
        check_val("ov_pd",      {30'd0, rx_pd}, 32'd0);
        check_val("ov_nover",   n_over - b_over, 32'd1);
        check_val("ov_nabort",  n_abort - b_abort, 32'd0);
        check_val("ov_cnt",     {16'd0, frame_cnt}, 32'd3);

        // CS rise on the same cycle as the 24th fall
        snap();
        send_frame(32'h02ABCD, 24, 1'b1);
        check_val("sc_nvalid", n_valid - b_valid, 32'd1);
        check_val("sc_nabort", n_abort - b_abort, 32'd0);
        check_val("sc_nover",  n_over - b_over, 32'd0);
        check_val("sc_data",   {16'd0, rx_data}, 32'hABCD);
        check_val("sc_pd",     {30'd0, rx_pd}, 32'd2);
        check_val("sc_cnt",    {16'd0, frame_cnt}, 32'd4);

        // Reset after 10 bits, with CS still low across reset release
        snap();
        spi_if.DA_CS = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            spi_if.DA_SDO = i[0];
            repeat (5) @(negedge clk);
            spi_if.DA_SCLK = 1'b0;
            repeat (5) @(negedge clk);
            spi_if.DA_SCLK = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        spi_if.DA_CS = 1'b1;
        repeat (8) @(negedge clk);
        check_val("rs_pulses", (n_valid - b_valid) + (n_abort - b_abort) + (n_over - b_over), 32'd0);
        check_val("rs_cnt",    {16'd0, frame_cnt}, 32'd0);
        check_val("rs_data",   {16'd0, rx_data}, 32'd0);
        snap();
        send_frame(32'h005555, 24, 1'b0);
        check_val("rs_f_data",   {16'd0, rx_data}, 32'h5555);
        check_val("rs_f_cnt",    {16'd0, frame_cnt}, 32'd1);
        check_val("rs_f_nvalid", n_valid - b_valid, 32'd1);
        check_val("rs_f_nabort", n_abort - b_abort, 32'd0);

        // Counter wrap: preload as if 65535 frames had been accepted
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        check_val("wr_preload", {16'd0, frame_cnt}, 32'hFFFF);
        snap();
        send_frame(32'h001111, 24, 1'b0);
        check_val("wr_cnt",    {16'd0, frame_cnt}, 32'd0);
        check_val("wr_nvalid", n_valid - b_valid, 32'd1);
        check_val("wr_data",   {16'd0, rx_data}, 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
